// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for the 16-way LED multiplexer. It drives the mux
// select through 0 .. 2^SEL_W-1. It holds each value for DWELL cycles and
// captures mux_data on the last cycle of each dwell.
//
// Optional feature: define MUX_SCAN_SIG_EN to build the rotate-left/XOR pass
// signature on sig. With the macro undefined, sig is constant zero.
//
// Handshake: start/stop/step are single-cycle pulses sampled on the rising
// edge, with priority stop > step > start. cap_valid is a single-cycle pulse
// that qualifies the new cap_data. done is a single-cycle pulse that marks the
// end of a single pass. There is no back-pressure: every capture is final.
// The FSM state is held in the named signal 'state' so checkers can bind to it.
module mux_scan_ctrl #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 8,
  parameter int DWELL  = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] mux_data,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sig
);

  localparam int               CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             do_tick;
  logic             last_sel;

  // A tick happens at the end of a dwell in RUN, or on a manual step in PAUSE.
  // stop masks both, so a stop that lands on a tick cycle loses the capture.
  always_comb begin
    do_tick  = 1'b0;
    last_sel = (sel == SEL_MAX);
    if (!stop) begin
      if ((state == RUN) && (cnt == '0)) do_tick = 1'b1;
      if ((state == PAUSE) && step)      do_tick = 1'b1;
    end
  end

  // Sequencer FSM. It registers the outputs and applies the shared tick action last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MUX_SCAN_SIG_EN
      sig       <= '0;
`endif
    end else begin
      cap_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sel   <= '0;
            cnt   <= RELOAD;
`ifdef MUX_SCAN_SIG_EN
            sig   <= '0;
`endif
          end
        end
        RUN: begin
          if (stop)          state <= PAUSE;
          else if (!do_tick) cnt   <= cnt - CNT_W'(1);
        end
        PAUSE: begin
          if (!stop && !step && start) state <= RUN;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (do_tick) begin
        cap_data  <= mux_data;
        cap_valid <= 1'b1;
        cnt       <= RELOAD;
`ifdef MUX_SCAN_SIG_EN
        sig       <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ mux_data;
`endif
        if (!last_sel) begin
          sel <= sel + SEL_W'(1);
        end else if (loop_en) begin
          // A wrap starts a fresh pass, so the signature starts again from zero.
          sel <= '0;
`ifdef MUX_SCAN_SIG_EN
          sig <= '0;
`endif
        end else begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

`ifndef MUX_SCAN_SIG_EN
  assign sig = '0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: bench for mux_scan_ctrl with DWELL=4. Directed scenarios use
// the mux pattern {4'hA, sel}. The randomized pass uses a random mux table and
// random stop/step/start pulses, and compares against an active-cycle model.
module tb_mux_scan_ctrl;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 8;
  localparam int D      = 4;
  localparam int NSEL   = 16;

`ifdef MUX_SCAN_SIG_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              step = 1'b0;
  logic              loop_en = 1'b0;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] cap_data;
  logic              cap_valid;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sig;

  logic [DATA_W-1:0] mux_tbl [NSEL];
  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_ctrl #(.SEL_W(SEL_W), .DATA_W(DATA_W), .DWELL(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .loop_en(loop_en), .mux_data(mux_data), .sel(sel), .cap_data(cap_data),
    .cap_valid(cap_valid), .busy(busy), .done(done), .sig(sig)
  );

  // Clock and mux model
  always #5 clk = ~clk;
  assign mux_data = mux_tbl[sel];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s_start, input logic s_stop, input logic s_step);
    start = s_start; stop = s_stop; step = s_step;
    cyc();
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  task automatic apply_reset();
    start = 1'b0; stop = 1'b0; step = 1'b0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic load_a_table();
    for (int i = 0; i < NSEL; i++) mux_tbl[i] = 8'hA0 | 8'(i);
  endtask

  function automatic logic [7:0] sig_next(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], s[7]} ^ d;
  endfunction

  task automatic test_reset();
    load_a_table();
    rst_n = 1'b0;
    cyc(); cyc();
    n_checks++; if (sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %0h expected 0", sel); end
    n_checks++; if (cap_data !== 8'h00) begin n_fail++; $display("FAIL reset_cap_data: got %0h expected 0", cap_data); end
    n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cap_valid: got %0b expected 0", cap_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_checks++; if (sig !== 8'h00) begin n_fail++; $display("FAIL reset_sig: got %0h expected 0", sig); end
    rst_n = 1'b1;
    // stop and step are ignored in IDLE
    pulse(1'b0, 1'b1, 1'b1);
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_busy: got %0b expected 0", busy); end
    n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_cap: got %0b expected 0", cap_valid); end
  endtask

  task automatic test_sweep();
    logic [7:0] ref_sig;
    logic [7:0] e_data;
    logic [3:0] e_sel;
    logic       e_v, e_d, e_b;
    apply_reset(); load_a_table(); loop_en = 1'b0; ref_sig = 8'h00;
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy_start: got %0b expected 1", busy); end
    for (int c = 1; c <= NSEL * D + 3; c++) begin
      cyc();
      e_v   = ((c % D) == 0) && (c <= NSEL * D);
      e_d   = (c == NSEL * D);
      e_b   = (c < NSEL * D);
      e_sel = (c / D > NSEL - 1) ? 4'hF : 4'(c / D);
      n_checks++; if (cap_valid !== e_v) begin n_fail++; $display("FAIL sweep_cap_valid c=%0d: got %0b expected %0b", c, cap_valid, e_v); end
      n_checks++; if (done !== e_d) begin n_fail++; $display("FAIL sweep_done c=%0d: got %0b expected %0b", c, done, e_d); end
      n_checks++; if (busy !== e_b) begin n_fail++; $display("FAIL sweep_busy c=%0d: got %0b expected %0b", c, busy, e_b); end
      n_checks++; if (sel !== e_sel) begin n_fail++; $display("FAIL sweep_sel c=%0d: got %0h expected %0h", c, sel, e_sel); end
      if (e_v) begin
        e_data  = 8'hA0 | 8'(c / D - 1);
        ref_sig = sig_next(ref_sig, e_data);
        n_checks++; if (cap_data !== e_data) begin n_fail++; $display("FAIL sweep_cap_data c=%0d: got %0h expected %0h", c, cap_data, e_data); end
      end
    end
    n_checks++; if (cap_data !== 8'hAF) begin n_fail++; $display("FAIL sweep_cap_hold: got %0h expected af", cap_data); end
    n_checks++; if (sig !== (SIG_ON ? ref_sig : 8'h00)) begin n_fail++; $display("FAIL sweep_sig: got %0h expected %0h", sig, SIG_ON ? ref_sig : 8'h00); end
  endtask

  task automatic test_loop();
    logic [7:0] e_data;
    logic       e_v;
    bit         seen;
    apply_reset(); load_a_table(); loop_en = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 40 * D; c++) begin
      cyc();
      e_v = ((c % D) == 0);
      n_checks++; if (cap_valid !== e_v) begin n_fail++; $display("FAIL loop_cap_valid c=%0d: got %0b expected %0b", c, cap_valid, e_v); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL loop_done c=%0d: got %0b expected 0", c, done); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy c=%0d: got %0b expected 1", c, busy); end
      n_checks++; if (sel !== 4'((c / D) % NSEL)) begin n_fail++; $display("FAIL loop_sel c=%0d: got %0h expected %0h", c, sel, 4'((c / D) % NSEL)); end
      if (e_v) begin
        e_data = 8'hA0 | 8'((c / D - 1) % NSEL);
        n_checks++; if (cap_data !== e_data) begin n_fail++; $display("FAIL loop_cap_data c=%0d: got %0h expected %0h", c, cap_data, e_data); end
      end
    end
    // Dropping loop_en mid-sweep ends the pass at the next final-select tick.
    loop_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2 * NSEL * D && !seen; c++) begin
      cyc();
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL loop_exit_done: got 0 expected 1 within budget"); end
    n_checks++; if (cap_data !== 8'hAF) begin n_fail++; $display("FAIL loop_exit_cap: got %0h expected af", cap_data); end
  endtask

  task automatic test_pause_step();
    logic [7:0] e_data;
    int wait_n;
    apply_reset(); load_a_table(); loop_en = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) cyc();
    n_checks++; if (sel !== 4'h3) begin n_fail++; $display("FAIL pause_pre_sel: got %0h expected 3", sel); end
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (sel !== 4'h3 || cap_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL pause_frozen i=%0d: got sel=%0h cv=%0b busy=%0b expected sel=3 cv=0 busy=1", i, sel, cap_valid, busy);
      end
      cyc();
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_checks++; if (cap_valid !== 1'b1 || cap_data !== 8'hA3 || sel !== 4'h4) begin
      n_fail++; $display("FAIL pause_step: got cv=%0b data=%0h sel=%0h expected cv=1 data=a3 sel=4", cap_valid, cap_data, sel);
    end
    wait_n = $urandom_range(1, 5);
    for (int i = 0; i < wait_n; i++) cyc();
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL resume_early_cap i=%0d: got %0b expected 0", i, cap_valid); end
    end
    cyc();
    n_checks++; if (cap_valid !== 1'b1 || cap_data !== 8'hA4 || sel !== 4'h5) begin
      n_fail++; $display("FAIL resume_cap: got cv=%0b data=%0h sel=%0h expected cv=1 data=a4 sel=5", cap_valid, cap_data, sel);
    end
    // Finish the pass purely by stepping; the last step ends in DONE.
    pulse(1'b0, 1'b1, 1'b0);
    for (int j = 5; j < NSEL; j++) begin
      pulse(1'b0, 1'b0, 1'b1);
      e_data = 8'hA0 | 8'(j);
      n_checks++; if (cap_valid !== 1'b1 || cap_data !== e_data) begin
        n_fail++; $display("FAIL step_cap j=%0d: got cv=%0b data=%0h expected cv=1 data=%0h", j, cap_valid, cap_data, e_data);
      end
      n_checks++; if (done !== (j == NSEL - 1) || busy !== (j != NSEL - 1)) begin
        n_fail++; $display("FAIL step_done j=%0d: got done=%0b busy=%0b expected done=%0b busy=%0b", j, done, busy, j == NSEL - 1, j != NSEL - 1);
      end
    end
    cyc();
    n_checks++; if (done !== 1'b0 || cap_valid !== 1'b0 || busy !== 1'b0 || sel !== 4'hF) begin
      n_fail++; $display("FAIL step_after_done: got done=%0b cv=%0b busy=%0b sel=%0h expected 0 0 0 f", done, cap_valid, busy, sel);
    end
  endtask

  task automatic test_priority();
    apply_reset(); load_a_table(); loop_en = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    cyc(); cyc();
    pulse(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (cap_valid !== 1'b0 || sel !== 4'h0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL prio_stop_start i=%0d: got cv=%0b sel=%0h busy=%0b expected 0 0 1", i, cap_valid, sel, busy);
      end
      cyc();
    end
    pulse(1'b1, 1'b0, 1'b0);
    cyc();
    n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL prio_resume_early: got %0b expected 0", cap_valid); end
    cyc();
    n_checks++; if (cap_valid !== 1'b1 || cap_data !== 8'hA0 || sel !== 4'h1) begin
      n_fail++; $display("FAIL prio_resume_cap: got cv=%0b data=%0h sel=%0h expected 1 a0 1", cap_valid, cap_data, sel);
    end
    cyc(); cyc(); cyc();
    // This stop lands exactly on the tick cycle.
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (cap_valid !== 1'b0 || sel !== 4'h1) begin
        n_fail++; $display("FAIL prio_stop_tick i=%0d: got cv=%0b sel=%0h expected 0 1", i, cap_valid, sel);
      end
      cyc();
    end
    pulse(1'b1, 1'b0, 1'b1);
    n_checks++; if (cap_valid !== 1'b1 || cap_data !== 8'hA1 || sel !== 4'h2) begin
      n_fail++; $display("FAIL prio_step_start: got cv=%0b data=%0h sel=%0h expected 1 a1 2", cap_valid, cap_data, sel);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++; if (cap_valid !== 1'b0 || sel !== 4'h2) begin
        n_fail++; $display("FAIL prio_still_paused i=%0d: got cv=%0b sel=%0h expected 0 2", i, cap_valid, sel);
      end
    end
    pulse(1'b0, 1'b1, 1'b1);
    n_checks++; if (cap_valid !== 1'b0 || sel !== 4'h2) begin
      n_fail++; $display("FAIL prio_stop_step: got cv=%0b sel=%0h expected 0 2", cap_valid, sel);
    end
    pulse(1'b1, 1'b0, 1'b0);
    cyc(); cyc(); cyc(); cyc();
    n_checks++; if (cap_valid !== 1'b1 || cap_data !== 8'hA2) begin
      n_fail++; $display("FAIL prio_final_cap: got cv=%0b data=%0h expected 1 a2", cap_valid, cap_data);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(); load_a_table(); loop_en = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 29; i++) cyc();
    n_checks++; if (sel !== 4'h7) begin n_fail++; $display("FAIL rmid_pre_sel: got %0h expected 7", sel); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (sel !== 4'h0 || busy !== 1'b0 || cap_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got sel=%0h busy=%0b cv=%0b done=%0b expected all 0", sel, busy, cap_valid, done);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_hold: got done=%0b busy=%0b expected 0 0", done, busy); end
    end
    rst_n = 1'b1;
    cyc();
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++; if (sel !== 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_restart: got sel=%0h busy=%0b expected 0 1", sel, busy); end
    cyc(); cyc(); cyc(); cyc();
    n_checks++; if (cap_valid !== 1'b1 || cap_data !== 8'hA0 || sel !== 4'h1) begin
      n_fail++; $display("FAIL rmid_first_cap: got cv=%0b data=%0h sel=%0h expected 1 a0 1", cap_valid, cap_data, sel);
    end
  endtask

  // Model: every select needs D active RUN cycles (cycles without stop);
  // a step in pause captures at once and restarts the dwell.
  task automatic test_random();
    logic [7:0] ref_sig;
    logic [7:0] e_data;
    logic       p_start, p_stop, p_step, cap;
    bit         running, finished;
    int         phase, idx, r;
    for (int it = 0; it < 4; it++) begin
      apply_reset(); loop_en = 1'b0;
      exp_q.delete();
      ref_sig = 8'h00;
      for (int i = 0; i < NSEL; i++) begin
        mux_tbl[i] = 8'($urandom);
        exp_q.push_back(mux_tbl[i]);
        ref_sig = sig_next(ref_sig, mux_tbl[i]);
      end
      pulse(1'b1, 1'b0, 1'b0);
      running = 1'b1; finished = 1'b0; phase = 0; idx = 0;
      for (int c = 0; c < 3000 && !finished; c++) begin
        r = $urandom_range(0, 15);
        p_start = 1'b0; p_stop = 1'b0; p_step = 1'b0;
        if (running) begin
          if (r == 0) p_stop = 1'b1; else if (r == 1) p_step = 1'b1; else if (r == 2) p_start = 1'b1;
        end else begin
          if (r < 3) p_start = 1'b1; else if (r == 3) p_step = 1'b1; else if (r == 4) p_stop = 1'b1;
        end
        pulse(p_start, p_stop, p_step);
        cap = 1'b0;
        if (running) begin
          if (p_stop) running = 1'b0;
          else begin phase++; if (phase == D) cap = 1'b1; end
        end else if (!p_stop) begin
          if (p_step) cap = 1'b1; else if (p_start) running = 1'b1;
        end
        if (cap) begin phase = 0; idx++; if (idx == NSEL) finished = 1'b1; end
        n_checks++; if (cap_valid !== cap) begin n_fail++; $display("FAIL rand_cap_valid it=%0d c=%0d: got %0b expected %0b", it, c, cap_valid, cap); end
        n_checks++; if (done !== (cap && finished)) begin n_fail++; $display("FAIL rand_done it=%0d c=%0d: got %0b expected %0b", it, c, done, cap && finished); end
        n_checks++; if (busy !== !finished) begin n_fail++; $display("FAIL rand_busy it=%0d c=%0d: got %0b expected %0b", it, c, busy, !finished); end
        if (cap) begin
          e_data = exp_q.pop_front();
          n_checks++; if (cap_data !== e_data) begin n_fail++; $display("FAIL rand_cap_data it=%0d c=%0d: got %0h expected %0h", it, c, cap_data, e_data); end
        end
      end
      n_checks++; if (!finished) begin n_fail++; $display("FAIL rand_timeout it=%0d: got %0d captures expected %0d", it, idx, NSEL); end
      n_checks++; if (sig !== (SIG_ON ? ref_sig : 8'h00)) begin n_fail++; $display("FAIL rand_sig it=%0d: got %0h expected %0h", it, sig, SIG_ON ? ref_sig : 8'h00); end
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_sweep();
    test_loop();
    test_pause_step();
    test_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer for the 16-way 8-bit LED multiplexer datapath: drives the 4-bit select, waits a programmable dwell per select value, then captures the mux output.
- Replaces manual switch stepping, so a full select sweep runs unattended on the board and in simulation.
- Sits between board controls (start/stop/step buttons, already debounced) and the mux select input; captured data feeds the LED register.

Parameters:
- SEL_W, 4, select width; sweep covers 0 .. 2^SEL_W-1.
- DATA_W, 8, mux output / capture width.
- DWELL, 100, clock cycles spent on each select value before capture; legal range 1 .. 2^16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin sweep (IDLE) or resume (PAUSE).
- stop  in  1  one-cycle pulse: pause a running sweep.
- step  in  1  one-cycle pulse: in PAUSE, force an immediate capture and advance.
- loop_en  in  1  1 = wrap after the last select and continue; 0 = single pass.
- mux_data  in  DATA_W  combinational mux output for the current sel.
- sel  out  SEL_W  registered mux select.
- cap_data  out  DATA_W  last captured mux_data.
- cap_valid  out  1  one-cycle pulse; cap_data updated this cycle.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle pulse at end of a single pass.
- sig  out  DATA_W  pass signature; see Optional Feature.

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, sel=0, cap_data=0, cap_valid=0, busy=0, done=0, sig=0, dwell counter=0. Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- IDLE + start: go to RUN, sel<=0, counter<=DWELL-1, sig<=0. stop and step are ignored in IDLE.
- RUN: counter decrements once per cycle. In the cycle where counter==0 (the "tick"):
  - cap_data<=mux_data and cap_valid<=1 on the next edge.
  - counter reloads to DWELL-1.
  - If sel != max: sel<=sel+1.
  - If sel == max and loop_en=1: sel<=0 and stay in RUN.
  - If sel == max and loop_en=0: go to DONE; sel holds max.
- Dwell timing: each select value is presented for exactly DWELL cycles. The capture samples mux_data on the last cycle of the dwell. First cap_valid appears DWELL cycles after the start edge. DWELL=1 captures every cycle.
- RUN + stop: go to PAUSE. sel and counter freeze. No capture occurs, even if the stop cycle coincides with a tick, because stop has priority over the tick.
- PAUSE + start: return to RUN; the counter continues from its frozen value.
- PAUSE + step: perform a tick action (capture, advance or wrap, reload counter) and stay in PAUSE. If this step completes a single pass, go to DONE.
- Simultaneous pulses: stop > step > start.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE. sel and cap_data hold until the next start.
- loop_en is sampled only at the final-select tick; changing it mid-sweep is legal.
- cap_valid is never high in IDLE or DONE, except the pulse for the final capture, which lands in the DONE cycle.
- Counter width is ceil(log2(DWELL)), minimum 1 bit.

Optional Feature:
- Macro: MUX_SCAN_SIG_EN.
- Defined: on every capture, sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ mux_data (rotate-left then XOR). sig clears on start from IDLE and at each loop wrap. sig holds after DONE. This gives a one-value pass/fail check against a precomputed signature.
- Undefined: sig is tied to 0, and no signature logic is synthesised.

Test Plan:
- Common setup: DWELL=4, mux model returns mux_data = {4'hA, sel}.
- Sweep: loop_en=0, start at t0 → 16 cap_valid pulses, exactly 4 cycles apart, with cap_data = A0, A1 … AF. Then one done pulse, then busy=0; sel stays F.
- Loop: loop_en=1, run 40 ticks → sel wraps F→0; cap_data after tick 17 = A0; done never asserts; busy stays 1.
- Pause/step: stop when sel=3 with counter=2 → sel frozen at 3 for 20 cycles, no cap_valid. Step → cap_data=A3, sel=4. Start → next capture after 4 cycles, cap_data=A4.
- Priority: stop and start in the same cycle while in RUN → enters PAUSE. Stop coincident with a tick → no capture, sel unchanged.
- Reset: drop rst_n mid-sweep at sel=7 → immediately sel=0, busy=0, cap_valid=0, done stays 0. Start after release → sweep restarts at 0.
- Signature (MUX_SCAN_SIG_EN defined): full single pass → sig equals the bench reference model's rotate-XOR of A0..AF. With the macro undefined → sig=0 throughout.
